// File: rtl/pmem_pkg.sv
// Shared types and constants for the pmem line responder.
// Imported by the responder top and its line RAM.
package pmem_pkg;

  localparam int PMEM_LINE_BITS   = 256;
  localparam int PMEM_OFFSET_BITS = 5;
  localparam int PMEM_INDEX_BITS  = 32 - PMEM_OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP
  } pmem_resp_state_t;

  typedef struct packed {
    logic                       is_write;
    logic [PMEM_INDEX_BITS-1:0] index;
    logic [PMEM_LINE_BITS-1:0]  wdata;
  } pmem_req_t;

endpackage

// File: rtl/pmem_line_ram.sv
// Single-port line array: synchronous write, registered read.
// The read register clears on rst; the array itself does not.
module pmem_line_ram
  import pmem_pkg::*;
#(
  parameter int LINE_BITS   = PMEM_LINE_BITS,
  parameter int DEPTH_LINES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           re,
  input  logic                           we,
  input  logic [$clog2(DEPTH_LINES)-1:0] addr,
  input  logic [LINE_BITS-1:0]           wdata,
  output logic [LINE_BITS-1:0]           rdata
);

  logic [LINE_BITS-1:0] mem [DEPTH_LINES];

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Registered read; holds until the next read.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/pmem_line_responder.sv
// Fixed-latency responder for the burst-memory line port.
// Optional PMEM_RESP_STATS_EN adds saturating rd/wr counters.
module pmem_line_responder
  import pmem_pkg::*;
#(
  parameter int LINE_BITS   = PMEM_LINE_BITS,
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [31:0]          pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp,
  output logic                 busy,
  output logic                 err
`ifdef PMEM_RESP_STATS_EN
  ,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count
`endif
);

  localparam int       IDX_W  = $clog2(DEPTH_LINES);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  pmem_resp_state_t state_q, state_d;
  pmem_req_t        req_q, req_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             any_req;
  logic             op_switch;
  logic             ram_re;
  logic             ram_we;
  logic [IDX_W-1:0] ram_addr;

  assign any_req   = pmem_read | pmem_write;
  assign op_switch = req_q.is_write ? pmem_read : pmem_write;

  // Next-state, request latch and RAM strobes.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = req_q.index[IDX_W-1:0];
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          req_d.is_write = pmem_write & ~pmem_read;
          req_d.index    = pmem_address[31:PMEM_OFFSET_BITS];
          req_d.wdata    = PMEM_LINE_BITS'(pmem_wdata);
          cnt_d          = LAT_M1;
          if (pmem_read & pmem_write) err_d = 1'b1;
          if (LATENCY == 1) begin
            state_d  = RESP;
            ram_re   = pmem_read;
            ram_addr = pmem_address[PMEM_OFFSET_BITS +: IDX_W];
          end else begin
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (!any_req) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          if (op_switch) err_d = 1'b1;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = RESP;
            ram_re  = ~req_q.is_write;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        ram_we  = req_q.is_write & ~rst;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, request and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      req_q   <= req_d;
    end
  end

  pmem_line_ram #(
    .LINE_BITS  (LINE_BITS),
    .DEPTH_LINES(DEPTH_LINES)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .re   (ram_re),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(req_q.wdata[LINE_BITS-1:0]),
    .rdata(pmem_rdata)
  );

  assign pmem_resp = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

  logic unused_bits;
  assign unused_bits = ^{pmem_address[PMEM_OFFSET_BITS-1:0],
                         req_q.index[PMEM_INDEX_BITS-1:IDX_W]};

`ifdef PMEM_RESP_STATS_EN
  // Saturating completion counters; aborts never reach RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (pmem_resp) begin
      if (req_q.is_write) begin
        if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
      end else begin
        if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed plus randomized bench for pmem_line_responder.
// Two instances: LATENCY=4 and LATENCY=1.
module tb_pmem_line_responder;

  localparam int LB = 256;
  localparam int DL = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic          r4, w4, resp4, busy4, err4;
  logic [31:0]   a4;
  logic [LB-1:0] wd4, rd4;
  logic          r1, w1, resp1, busy1, err1;
  logic [31:0]   a1;
  logic [LB-1:0] wd1, rd1;
`ifdef PMEM_RESP_STATS_EN
  logic [31:0]   rc4, wc4, rc1, wc1;
`endif

  pmem_line_responder #(
    .LINE_BITS(LB), .DEPTH_LINES(DL), .LATENCY(4)
  ) dut4 (
    .clk(clk), .rst(rst),
    .pmem_read(r4), .pmem_write(w4),
    .pmem_address(a4), .pmem_wdata(wd4),
    .pmem_rdata(rd4), .pmem_resp(resp4),
    .busy(busy4), .err(err4)
`ifdef PMEM_RESP_STATS_EN
    , .rd_count(rc4), .wr_count(wc4)
`endif
  );

  pmem_line_responder #(
    .LINE_BITS(LB), .DEPTH_LINES(DL), .LATENCY(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .pmem_read(r1), .pmem_write(w1),
    .pmem_address(a1), .pmem_wdata(wd1),
    .pmem_rdata(rd1), .pmem_resp(resp1),
    .busy(busy1), .err(err1)
`ifdef PMEM_RESP_STATS_EN
    , .rd_count(rc1), .wr_count(wc1)
`endif
  );

  logic [LB-1:0] mem_m [DL];
  logic [LB-1:0] last_rd;

  task automatic chk(input string tag,
                     input logic [LB-1:0] obs,
                     input logic [LB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LB-1:0] rnd256();
    logic [LB-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int lidx(input logic [31:0] addr);
    return int'(addr[14:5]);
  endfunction

  // One complete request on the LATENCY=4 instance.
  task automatic op4(input bit wr, input bit rd,
                     input logic [31:0] addr,
                     input logic [LB-1:0] wd);
    int i;
    i = lidx(addr);
    @(negedge clk);
    r4 = rd; w4 = wr; a4 = addr; wd4 = wd;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("resp4", resp4, k == 4);
      chk("busy4", busy4, k <= 4);
      if (k == 2) begin
        a4  = $urandom;
        wd4 = rnd256();
      end
      if (k == 4) begin
        chk("rdata4", rd4, rd ? mem_m[i] : last_rd);
        r4 = 1'b0; w4 = 1'b0;
      end
    end
    if (rd) last_rd = mem_m[i];
    else if (wr) mem_m[i] = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    r4 = 1'b0; w4 = 1'b0; r1 = 1'b0; w1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    chk("rst_resp", resp4, 1'b0);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_err", err4, 1'b0);
    chk("rst_rdata", rd4, '0);
    chk("rst_resp1", resp1, 1'b0);
  endtask

  logic [LB-1:0] va, vb, v2;
  logic [31:0]   ra;
  int            ri;
  bit            written [DL];

  initial begin
    rst = 1'b1;
    r4 = 0; w4 = 0; a4 = 0; wd4 = 0;
    r1 = 0; w1 = 0; a1 = 0; wd1 = 0;
    last_rd = '0;
    do_reset();

    // basic write then read
    op4(1, 0, 32'h0000_0040, {8{32'hDEAD_BEEF}});
    op4(0, 1, 32'h0000_0040, '0);
    chk("basic_data", last_rd, {8{32'hDEAD_BEEF}});

    // offset ignored, index wrap
    op4(1, 0, 32'h0000_0060, 256'h1);
    op4(0, 1, 32'h0000_007F, '0);
    op4(0, 1, 32'h0000_8060, '0);
    chk("wrap_data", rd4, 256'h1);
    chk("no_err", err4, 1'b0);

    // both requests high -> read, err set, line unchanged
    op4(1, 0, 32'h0000_0100, 256'h55);
    op4(1, 1, 32'h0000_0100, 256'hBAD);
    chk("both_err", err4, 1'b1);
    op4(0, 1, 32'h0000_0100, '0);
    chk("both_line", rd4, 256'h55);

    // abort of a read dropped in cycle N+2
    do_reset();
    @(negedge clk);
    r4 = 1; a4 = 32'h40;
    @(negedge clk);
    chk("ab_busy1", busy4, 1'b1);
    chk("ab_err1", err4, 1'b0);
    @(negedge clk);
    chk("ab_resp2", resp4, 1'b0);
    r4 = 0;
    @(negedge clk);
    chk("ab_err3", err4, 1'b1);
    chk("ab_busy3", busy4, 1'b0);
    chk("ab_resp3", resp4, 1'b0);
    @(negedge clk);
    chk("ab_resp4", resp4, 1'b0);
    op4(1, 0, 32'h0000_0200, 256'hA);
    chk("ab_sticky", err4, 1'b1);

    // reset in the middle of a write
    @(negedge clk);
    w4 = 1; a4 = 32'h200; wd4 = 256'hB;
    @(negedge clk);
    @(negedge clk);
    rst = 1; w4 = 0;
    @(negedge clk);
    chk("mr_resp", resp4, 1'b0);
    chk("mr_err", err4, 1'b0);
    chk("mr_busy", busy4, 1'b0);
    rst = 0;
    last_rd = '0;
    @(negedge clk);
    chk("mr_resp2", resp4, 1'b0);
    op4(0, 1, 32'h0000_0200, '0);
    chk("mr_keep", rd4, 256'hA);

    // op switch mid-flight: latched write wins
    do_reset();
    v2 = rnd256();
    @(negedge clk);
    w4 = 1; a4 = 32'h300; wd4 = v2;
    @(negedge clk);
    @(negedge clk);
    w4 = 0; r4 = 1; a4 = 32'h40; wd4 = '0;
    @(negedge clk);
    chk("sw_err", err4, 1'b1);
    @(negedge clk);
    chk("sw_resp", resp4, 1'b1);
    chk("sw_rdata", rd4, last_rd);
    r4 = 0;
    @(negedge clk);
    chk("sw_resp2", resp4, 1'b0);
    mem_m[lidx(32'h300)] = v2;
    op4(0, 1, 32'h0000_0300, '0);

    // randomized traffic over a small set of lines
    for (int n = 0; n < 40; n++) begin
      ri = 16 + int'($urandom_range(0, 7));
      ra = ($urandom & 32'hFFFF_801F) | (32'(ri) << 5);
      if (!written[ri] || ($urandom_range(0, 1) == 0)) begin
        op4(1, 0, ra, rnd256());
        written[ri] = 1'b1;
      end else begin
        op4(0, 1, ra, '0);
      end
    end

    // LATENCY=1: seed a line, reset, then back-to-back traffic
    va = rnd256();
    vb = rnd256();
    @(negedge clk);
    w1 = 1; a1 = 32'h400; wd1 = va;
    @(negedge clk);
    chk("l1_wresp", resp1, 1'b1);
    w1 = 0;
    @(negedge clk);
    chk("l1_idle", resp1, 1'b0);
    do_reset();
    @(negedge clk);
    r1 = 1; a1 = 32'h400;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("l1_resp", resp1, (j % 2) == 0);
      if (j == 0 || j == 2) chk("l1_rdata", rd1, va);
      if (j == 2) begin
        r1 = 0; w1 = 1; a1 = 32'h420; wd1 = vb;
      end
      if (j == 4) begin
        chk("l1_hold", rd1, va);
        w1 = 0;
      end
    end
`ifdef PMEM_RESP_STATS_EN
    chk("rd_count", 256'(rc1), 256'd2);
    chk("wr_count", 256'(wc1), 256'd1);
`endif
    @(negedge clk);
    r1 = 1; a1 = 32'h420;
    @(negedge clk);
    chk("l1_rd2", rd1, vb);
    r1 = 0;
    @(negedge clk);
    chk("l1_err", err1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
